// File: rtl/view_param_loader_pkg.sv
// Shared definitions for the view parameter loader: FSM encodings, mask bit
// positions of the four view fields and error codes.
package view_param_loader_pkg;

   typedef enum logic [2:0] {
      ST_HUNT = 3'd0,
      ST_MASK = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_PEND = 3'd4
   } state_t;

   localparam int IDX_X     = 0;
   localparam int IDX_Y     = 1;
   localparam int IDX_ANGLE = 2;
   localparam int IDX_ZOOM  = 3;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_MASK    = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   // Data bytes fill fields in ascending mask bit order.
   function automatic logic [1:0] lowest_bit(input logic [3:0] m);
      if (m[0])      lowest_bit = 2'd0;
      else if (m[1]) lowest_bit = 2'd1;
      else if (m[2]) lowest_bit = 2'd2;
      else           lowest_bit = 2'd3;
   endfunction

endpackage

// File: rtl/view_param_loader_timeout.sv
// Inter-byte idle counter; expire fires on the cycle the count sits at
// TIMEOUT-1 while still enabled.
module view_param_loader_timeout #(
   parameter int TIMEOUT = 1024
) (
   input  logic ACLK,
   input  logic ARESETn,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int W = $clog2(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] count;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn)    count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + 1'b1;
   end

   assign expire = enable & (count == LAST);

endmodule

// File: rtl/view_param_loader.sv
// Parses SYNC/MASK/DATA/CSUM packets into shadow view registers and commits
// them to the renderer outputs atomically on frame_start.
module view_param_loader
   import view_param_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         TIMEOUT   = 1024,
   parameter logic [7:0] RST_X     = 8'h80,
   parameter logic [7:0] RST_Y     = 8'h80,
   parameter logic [7:0] RST_ANGLE = 8'h00,
   parameter logic [7:0] RST_ZOOM  = 8'h40
) (
   input  logic       ACLK,
   input  logic       ARESETn,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   input  logic       frame_start,
   output logic [7:0] x_center,
   output logic [7:0] y_center,
   output logic [7:0] angle,
   output logic [7:0] zoom,
   output logic       pending,
   output logic       ack,
   output logic       err,
   output logic [1:0] err_code,
   output logic [2:0] state_dbg
);

   // Byte channel: a byte transfers on any ACLK edge where rx_valid and
   // rx_ready are both high; rx_ready does not depend on rx_valid.

   localparam logic [3:0][7:0] RST_VIEW = {RST_ZOOM, RST_ANGLE, RST_Y, RST_X};

   state_t          state_q, state_d;
   logic [3:0]      mask_q, mask_d, orig_q, orig_d;
   logic [7:0]      csum_q, csum_d;
   logic [3:0][7:0] stage_q, stage_d, shadow_q, shadow_d, view_q, view_d;
   logic            ack_d, err_d;
   logic [1:0]      code_q, code_d;
   logic            fire, in_pkt, tmo_clear, tmo_enable, expire;

   assign rx_ready   = (state_q != ST_PEND);
   assign fire       = rx_valid & rx_ready;
   assign in_pkt     = (state_q == ST_MASK) || (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign tmo_enable = in_pkt & ~fire;
   assign tmo_clear  = ~in_pkt | fire | expire;

   view_param_loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expire  (expire)
   );

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q  <= ST_HUNT;
         mask_q   <= '0;
         orig_q   <= '0;
         csum_q   <= '0;
         stage_q  <= RST_VIEW;
         shadow_q <= RST_VIEW;
         view_q   <= RST_VIEW;
         ack      <= 1'b0;
         err      <= 1'b0;
         code_q   <= ERR_NONE;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         orig_q   <= orig_d;
         csum_q   <= csum_d;
         stage_q  <= stage_d;
         shadow_q <= shadow_d;
         view_q   <= view_d;
         ack      <= ack_d;
         err      <= err_d;
         code_q   <= code_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      orig_d   = orig_q;
      csum_d   = csum_q;
      stage_d  = stage_q;
      shadow_d = shadow_q;
      view_d   = view_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      code_d   = code_q;
      case (state_q)
         ST_HUNT: if (fire && rx_data == SYNC_BYTE) state_d = ST_MASK;
         ST_MASK: if (fire) begin
            if (rx_data[7:4] != 4'd0) begin
               err_d   = 1'b1;
               code_d  = ERR_MASK;
               state_d = ST_HUNT;
            end else begin
               mask_d  = rx_data[3:0];
               orig_d  = rx_data[3:0];
               csum_d  = rx_data;
               state_d = (rx_data[3:0] != 4'd0) ? ST_DATA : ST_CSUM;
            end
         end
         ST_DATA: if (fire) begin
            stage_d[lowest_bit(mask_q)] = rx_data;
            csum_d = csum_q ^ rx_data;
            mask_d = mask_q & (mask_q - 4'd1);
            if (mask_d == 4'd0) state_d = ST_CSUM;
         end
         ST_CSUM: if (fire) begin
            if (rx_data == csum_q) begin
               for (int i = 0; i < 4; i++)
                  if (orig_q[i]) shadow_d[i] = stage_q[i];
               ack_d   = 1'b1;
               state_d = (orig_q != 4'd0) ? ST_PEND : ST_HUNT;
            end else begin
               err_d   = 1'b1;
               code_d  = ERR_CSUM;
               state_d = ST_HUNT;
            end
         end
         ST_PEND: if (frame_start) begin
            view_d  = shadow_q;
            state_d = ST_HUNT;
         end
         default: state_d = ST_HUNT;
      endcase
      // expire only asserts in a packet state with no byte accepted.
      if (expire) begin
         err_d   = 1'b1;
         code_d  = ERR_TIMEOUT;
         state_d = ST_HUNT;
      end
   end

   assign x_center  = view_q[IDX_X];
   assign y_center  = view_q[IDX_Y];
   assign angle     = view_q[IDX_ANGLE];
   assign zoom      = view_q[IDX_ZOOM];
   assign pending   = (state_q == ST_PEND);
   assign err_code  = code_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_view_param_loader.sv
// Directed bench for view_param_loader (TIMEOUT = 16): packet parsing,
// error paths, timeout boundary, frame_start commit and reset during PEND.
module tb_view_param_loader;

   logic       ACLK = 1'b0;
   logic       ARESETn = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic       frame_start = 1'b0;
   logic [7:0] x_center, y_center, angle, zoom;
   logic       pending, ack, err;
   logic [1:0] err_code;
   logic [2:0] state_dbg;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] prev_view;

   view_param_loader #(.TIMEOUT(16)) dut (
      .ACLK        (ACLK),
      .ARESETn     (ARESETn),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .frame_start (frame_start),
      .x_center    (x_center),
      .y_center    (y_center),
      .angle       (angle),
      .zoom        (zoom),
      .pending     (pending),
      .ack         (ack),
      .err         (err),
      .err_code    (err_code),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_view(input string tag, input logic [31:0] expv);
      check(tag, {x_center, y_center, angle, zoom}, expv);
   endtask

   // drivers: called at a negedge, return at the negedge after the transfer
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge ACLK);
      @(negedge ACLK);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge ACLK);
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      @(posedge ACLK);
      @(negedge ACLK);
      frame_start = 1'b0;
   endtask

   // scoreboard: every change of the committed view must match the next
   // expected commit
   always @(negedge ACLK) begin
      if (!ARESETn) begin
         prev_view = {x_center, y_center, angle, zoom};
      end else if ({x_center, y_center, angle, zoom} !== prev_view) begin
         if (exp_q.size() == 0) begin
            check("unexpected_commit", {x_center, y_center, angle, zoom}, prev_view);
         end else begin
            check("commit_sb", {x_center, y_center, angle, zoom}, exp_q.pop_front());
         end
         prev_view = {x_center, y_center, angle, zoom};
      end
   end

   initial begin
      idle(3);
      // reset state
      check_view("reset_view", 32'h8080_0040);
      check("reset_pending", pending, 0);
      check("reset_ack", ack, 0);
      check("reset_err", err, 0);
      check("reset_err_code", err_code, 0);
      check("reset_rx_ready", rx_ready, 1);
      ARESETn = 1'b1;
      idle(2);

      // full update
      send_byte(8'hA5); send_byte(8'h0F); send_byte(8'h10);
      send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
      check("full_ack_early", ack, 0);
      send_byte(8'h4F);
      check("full_ack", ack, 1);
      check("full_err", err, 0);
      check("full_pending", pending, 1);
      check("full_rx_ready", rx_ready, 0);
      check_view("full_before_commit", 32'h8080_0040);
      idle(1);
      check("full_ack_pulse", ack, 0);
      check("full_pending_hold", pending, 1);
      check_view("full_still_old", 32'h8080_0040);
      exp_q.push_back(32'h1020_3040);
      pulse_frame();
      check_view("full_commit", 32'h1020_3040);
      check("full_pending_clr", pending, 0);
      check("full_rx_ready_back", rx_ready, 1);

      // partial update: angle only
      send_byte(8'hA5); send_byte(8'h04); send_byte(8'h5A); send_byte(8'h5E);
      check("part_ack", ack, 1);
      check("part_rx_ready", rx_ready, 0);
      idle(2);
      check("part_rx_ready_hold", rx_ready, 0);
      exp_q.push_back(32'h1020_5A40);
      pulse_frame();
      check_view("part_commit", 32'h1020_5A40);

      // bad checksum, then corrected packet
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h33); send_byte(8'h00);
      check("csum_err", err, 1);
      check("csum_code", err_code, 2);
      check("csum_no_ack", ack, 0);
      check("csum_no_pending", pending, 0);
      idle(1);
      check("csum_err_pulse", err, 0);
      check("csum_code_held", err_code, 2);
      pulse_frame();
      check_view("csum_no_commit", 32'h1020_5A40);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h33); send_byte(8'h32);
      check("csum_fix_ack", ack, 1);
      exp_q.push_back(32'h3320_5A40);
      pulse_frame();
      check_view("csum_fix_commit", 32'h3320_5A40);

      // garbage then bad mask, then a no-op packet
      send_byte(8'h00);
      check("garbage_00", err, 0);
      send_byte(8'hFF);
      check("garbage_ff", err, 0);
      send_byte(8'hA5); send_byte(8'h10);
      check("mask_err", err, 1);
      check("mask_code", err_code, 1);
      send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
      check("noop_ack", ack, 1);
      check("noop_no_pending", pending, 0);
      check("noop_rx_ready", rx_ready, 1);

      // timeout exactly 16 cycles after the last byte
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      idle(15);
      check("tmo_not_yet", err, 0);
      idle(1);
      check("tmo_err", err, 1);
      check("tmo_code", err_code, 3);
      pulse_frame();
      check_view("tmo_no_commit", 32'h3320_5A40);

      // byte on the last idle cycle prevents the timeout
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      idle(15);
      send_byte(8'h22);
      check("tmo_saved", err, 0);
      send_byte(8'h30);
      check("tmo_saved_ack", ack, 1);
      exp_q.push_back(32'h1122_5A40);
      pulse_frame();
      check_view("tmo_saved_commit", 32'h1122_5A40);

      // frame_start coincident with the checksum byte
      send_byte(8'hA5); send_byte(8'h08); send_byte(8'h77);
      frame_start = 1'b1;
      send_byte(8'h7F);
      frame_start = 1'b0;
      check("coinc_ack", ack, 1);
      check("coinc_pending", pending, 1);
      check_view("coinc_no_commit", 32'h1122_5A40);
      idle(2);
      check_view("coinc_wait", 32'h1122_5A40);
      exp_q.push_back(32'h1122_5A77);
      pulse_frame();
      check_view("coinc_commit", 32'h1122_5A77);

      // reset asserted during PEND
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h99); send_byte(8'h98);
      check("rst_pend_entered", pending, 1);
      #2 ARESETn = 1'b0;
      #1;
      check_view("rst_view", 32'h8080_0040);
      check("rst_pending", pending, 0);
      check("rst_rx_ready", rx_ready, 1);
      check("rst_ack", ack, 0);
      idle(2);
      ARESETn = 1'b1;
      idle(1);
      pulse_frame();
      check_view("rst_shadow_lost", 32'h8080_0040);

      check("sb_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
